program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 27 ++
 rtl/program_loader_instr_assembler.sv | 32 +++
 rtl/program_loader.sv | 123 ++++++++++++
 tb/tb_program_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: widths, FSM state encoding, ready decode.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the trailing XOR checksum byte).
package program_loader_pkg;

    localparam int unsigned BYTE_W              = 8;
    localparam int unsigned COUNT_W             = 16;
    localparam int unsigned WORD_W              = 32;
    localparam int unsigned IDX_W               = 2;
    localparam int unsigned INSTR_WIDTH_DEFAULT = 28;

    typedef enum logic [2:0] {
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_WRITE,
        ST_FINISH,
        ST_DONE,
        ST_ERROR,
        ST_CHECK
    } state_t;

    // States in which the loader takes a byte from the stream.
    function automatic logic byte_ready(input state_t s);
        return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/program_loader_instr_assembler.sv
// Byte shift register and 0..3 byte counter that builds one 32-bit instruction word.
module instr_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] data_byte,
    output logic [WORD_W-1:0] word_c,
    output logic              complete_c,
    output logic              first_c
);

    logic [WORD_W-BYTE_W-1:0] shreg;
    logic [IDX_W-1:0]         idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            idx   <= '0;
        end else if (shift_en) begin
            shreg <= {shreg[WORD_W-2*BYTE_W-1:0], data_byte};
            idx   <= idx + IDX_W'(1);
        end
    end

    // Word including the byte on the input, so the top can latch it on the final byte.
    assign word_c     = {shreg, data_byte};
    assign complete_c = (idx == IDX_W'(3));
    assign first_c    = (idx == IDX_W'(0));

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed program into instruction RAM, holding the CPU in reset until done.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte checked in CHECK).
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEFAULT
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [BYTE_W-1:0]      iByte,
    input  logic                   iByteValid,
    output logic                   oByteReady,
    output logic                   oWriteEnable,
    output logic [ADDR_WIDTH-1:0]  oWriteAddress,
    output logic [INSTR_WIDTH-1:0] oWriteData,
    output logic                   oCpuReset,
    output logic                   oDone,
    output logic                   oError
);

    state_t              state, state_n;
    logic [BYTE_W-1:0]   hdr_hi;
    logic [COUNT_W-1:0]  remaining;
    logic                accept_c, bad_nibble_c, shift_c;
    logic [WORD_W-1:0]   word_c;
    logic                complete_c, first_c;
    logic                ready_n, write_n, done_n, error_n, cpu_reset_n;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum;
`endif

    assign accept_c     = iByteValid && oByteReady;
    assign bad_nibble_c = first_c && (iByte[7:4] != 4'd0);
    assign shift_c      = accept_c && (state == ST_DATA) && !bad_nibble_c;

    instr_assembler u_asm (
        .clk        (Clock),
        .rst        (Reset),
        .shift_en   (shift_c),
        .data_byte  (iByte),
        .word_c     (word_c),
        .complete_c (complete_c),
        .first_c    (first_c)
    );

    // Next-state and Moore output decode.
    always_comb begin
        state_n = state;
        case (state)
            ST_HDR_HI: if (accept_c) state_n = ST_HDR_LO;
            ST_HDR_LO: begin
                if (accept_c) state_n = ({hdr_hi, iByte} == COUNT_W'(0)) ? ST_FINISH : ST_DATA;
            end
            ST_DATA: begin
                if (accept_c) begin
                    if (bad_nibble_c)    state_n = ST_ERROR;
                    else if (complete_c) state_n = ST_WRITE;
                end
            end
            ST_WRITE:  state_n = (remaining == COUNT_W'(1)) ? ST_FINISH : ST_DATA;
`ifdef LOADER_CHECKSUM_EN
            ST_FINISH: state_n = ST_CHECK;
            ST_CHECK:  if (accept_c) state_n = (iByte == csum) ? ST_DONE : ST_ERROR;
`else
            ST_FINISH: state_n = ST_DONE;
`endif
            ST_DONE:   state_n = ST_DONE;
            ST_ERROR:  state_n = ST_ERROR;
            default:   state_n = ST_ERROR;
        endcase
        ready_n     = byte_ready(state_n);
        write_n     = (state_n == ST_WRITE);
        done_n      = (state_n == ST_DONE);
        error_n     = (state_n == ST_ERROR);
        cpu_reset_n = (state_n != ST_DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= ST_HDR_HI;
            oByteReady   <= 1'b1;
            oWriteEnable <= 1'b0;
            oCpuReset    <= 1'b1;
            oDone        <= 1'b0;
            oError       <= 1'b0;
        end else begin
            state        <= state_n;
            oByteReady   <= ready_n;
            oWriteEnable <= write_n;
            oCpuReset    <= cpu_reset_n;
            oDone        <= done_n;
            oError       <= error_n;
        end
    end

    // Header capture, remaining-word count, address and assembled data.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hdr_hi        <= '0;
            remaining     <= '0;
            oWriteAddress <= '0;
            oWriteData    <= '0;
        end else begin
            if (accept_c && (state == ST_HDR_HI)) hdr_hi <= iByte;
            if (accept_c && (state == ST_HDR_LO)) remaining <= {hdr_hi, iByte};
            if (state == ST_WRITE) begin
                remaining     <= remaining - COUNT_W'(1);
                oWriteAddress <= oWriteAddress + ADDR_WIDTH'(1);
            end
            if (shift_c && complete_c) oWriteData <= INSTR_WIDTH'(word_c);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every accepted byte, header included.
    always_ff @(posedge Clock) begin
        if (Reset)         csum <= '0;
        else if (accept_c) csum <= csum ^ iByte;
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed streams plus randomized streams vs a stream-parsing model.
module tb_program_loader;

    localparam int unsigned AW = 16;
    localparam int unsigned IW = 28;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [7:0]    iByte = 8'h00;
    logic          iByteValid = 1'b0;
    logic          oByteReady, oWriteEnable, oCpuReset, oDone, oError;
    logic [AW-1:0] oWriteAddress;
    logic [IW-1:0] oWriteData;

    always #5 Clock = ~Clock;

    program_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iByte         (iByte),
        .iByteValid    (iByteValid),
        .oByteReady    (oByteReady),
        .oWriteEnable  (oWriteEnable),
        .oWriteAddress (oWriteAddress),
        .oWriteData    (oWriteData),
        .oCpuReset     (oCpuReset),
        .oDone         (oDone),
        .oError        (oError)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Observed write strobes and protocol invariants, sampled mid-cycle.
    logic [AW-1:0] got_addr_q[$];
    logic [IW-1:0] got_data_q[$];
    int   strobe_ready_viol = 0;
    int   cpu_viol = 0;
    int   last_we_cyc = -1;
    int   done_rise_cyc = -1;
    logic prev_done = 1'b0;

    always @(negedge Clock) begin
        if (oWriteEnable === 1'b1) begin
            got_addr_q.push_back(oWriteAddress);
            got_data_q.push_back(oWriteData);
            last_we_cyc <= cyc;
            if (oByteReady !== 1'b0) strobe_ready_viol <= strobe_ready_viol + 1;
        end
        if (oCpuReset !== !oDone) cpu_viol <= cpu_viol + 1;
        if (oDone === 1'b1 && prev_done !== 1'b1) done_rise_cyc <= cyc;
        prev_done <= oDone;
    end

    // Reference model: parse the byte stream by the format rules.
    logic [7:0]    stream[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [IW-1:0] exp_data_q[$];
    int            exp_consumed;
    bit            exp_done, exp_err;
    int            accepted;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        stream.push_back(b);
    endtask

    task automatic put4(input logic [31:0] w);
        put(w[31:24]); put(w[23:16]); put(w[15:8]); put(w[7:0]);
    endtask

    task automatic put_checksum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
        put(x);
`endif
    endtask

    task automatic model();
        int n, pos;
        logic [7:0]  cs;
        logic [31:0] w;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n   = int'({stream[0], stream[1]});
        cs  = stream[0] ^ stream[1];
        pos = 2;
        for (int i = 0; i < n && !exp_err; i++) begin
            if (stream[pos][7:4] != 4'h0) begin
                exp_err = 1'b1;
                pos++;
            end else begin
                w = {stream[pos], stream[pos+1], stream[pos+2], stream[pos+3]};
                cs = cs ^ stream[pos] ^ stream[pos+1] ^ stream[pos+2] ^ stream[pos+3];
                exp_addr_q.push_back(AW'(i));
                exp_data_q.push_back(IW'(w));
                pos += 4;
            end
        end
        if (!exp_err) begin
`ifdef LOADER_CHECKSUM_EN
            if (stream[pos] == cs) exp_done = 1'b1;
            else                   exp_err  = 1'b1;
            pos++;
`else
            exp_done = 1'b1;
`endif
        end
        exp_consumed = pos;
    endtask

    function automatic logic pick_valid(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // Offer the stream under a valid pattern; mode 0 always, 1 every other cycle, 2 random.
    task automatic run_stream(input int mode);
        int  idx = 0;
        int  settle = 0;
        int  budget = stream.size() * 4 + 40;
        bit  acc;
        got_addr_q.delete();
        got_data_q.delete();
        strobe_ready_viol = 0;
        cpu_viol = 0;
        done_rise_cyc = -1;
        last_we_cyc = -1;
        accepted = 0;
        iByte = stream[0];
        iByteValid = pick_valid(mode, 0);
        for (int c = 1; c < budget; c++) begin
            @(negedge Clock);
            acc = (iByteValid === 1'b1) && (oByteReady === 1'b1);
            @(posedge Clock);
            #1;
            if (acc) begin
                idx++;
                accepted++;
            end
            if (idx >= stream.size()) settle++;
            if (settle > 8) break;
            iByte = (idx < stream.size()) ? stream[idx] : 8'h00;
            iByteValid = (idx < stream.size()) ? pick_valid(mode, c) : 1'b0;
        end
        iByteValid = 1'b0;
        @(negedge Clock);
    endtask

    task automatic check_run(input string tag);
        int n;
        check({tag, "_nwrites"}, 64'(got_addr_q.size()), 64'(exp_addr_q.size()));
        n = (got_addr_q.size() < exp_addr_q.size()) ? got_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d_addr", tag, i), 64'(got_addr_q[i]), 64'(exp_addr_q[i]));
            check($sformatf("%s_w%0d_data", tag, i), 64'(got_data_q[i]), 64'(exp_data_q[i]));
        end
        check({tag, "_accepted"},   64'(accepted), 64'(exp_consumed));
        check({tag, "_done"},       64'(oDone), 64'(exp_done));
        check({tag, "_error"},      64'(oError), 64'(exp_err));
        check({tag, "_cpu_reset"},  64'(oCpuReset), 64'(!exp_done));
        check({tag, "_ready"},      64'(oByteReady), 64'(1'b0));
        check({tag, "_we_ready"},   64'(strobe_ready_viol), 64'(0));
        check({tag, "_cpu_inv"},    64'(cpu_viol), 64'(0));
    endtask

    task automatic do_reset(input bit full_check);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        iByteValid = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        check("rst_ready", 64'(oByteReady), 64'(1'b1));
        check("rst_we",    64'(oWriteEnable), 64'(1'b0));
        check("rst_addr",  64'(oWriteAddress), 64'(0));
        if (full_check) begin
            check("rst_data",  64'(oWriteData), 64'(0));
            check("rst_cpu",   64'(oCpuReset), 64'(1'b1));
            check("rst_done",  64'(oDone), 64'(1'b0));
            check("rst_error", 64'(oError), 64'(1'b0));
        end
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    initial begin : fail_safe
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [7:0] nb;
        logic [31:0] w;

        do_reset(1'b1);

        // Single instruction, continuous valid.
        stream.delete();
        put(8'h00); put(8'h01); put4(32'h01234567); put_checksum();
        model();
        run_stream(0);
        check_run("one_word");
`ifndef LOADER_CHECKSUM_EN
        lat = done_rise_cyc - last_we_cyc;
        check("done_latency", 64'((lat >= 1) && (lat <= 2)), 64'(1'b1));
`endif

        // Two instructions with iByteValid toggling.
        do_reset(1'b0);
        stream.delete();
        put(8'h00); put(8'h02); put4(32'h0ABCDEF1); put4(32'h00000042); put_checksum();
        model();
        run_stream(1);
        check_run("two_words");

        // Empty program.
        do_reset(1'b0);
        stream.delete();
        put(8'h00); put(8'h00); put_checksum();
        model();
        run_stream(0);
        check_run("empty");

        // Nonzero upper nibble aborts, trailing bytes refused.
        do_reset(1'b0);
        stream.delete();
        put(8'h00); put(8'h01); put(8'hF0); put(8'h00); put(8'h00); put(8'h00);
        model();
        run_stream(0);
        check_run("bad_nibble");

        // Reset after two data bytes, then a fresh stream from address 0.
        do_reset(1'b0);
        stream.delete();
        put(8'h00); put(8'h02); put(8'h01); put(8'h23);
        run_stream(0);
        check("partial_nwrites", 64'(got_addr_q.size()), 64'(0));
        do_reset(1'b0);
        stream.delete();
        put(8'h00); put(8'h01); put4(32'h0ABCDEF0); put_checksum();
        model();
        run_stream(0);
        check_run("after_reset");

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum: write happens, then error.
        do_reset(1'b0);
        stream.delete();
        put(8'h00); put(8'h01); put4(32'h01234567);
        put(8'h00 ^ 8'h01 ^ 8'h01 ^ 8'h23 ^ 8'h45 ^ 8'h67 ^ 8'h01);
        model();
        run_stream(0);
        check_run("bad_checksum");
`endif

        // Randomized streams, occasional bad nibble and trailing junk.
        for (int t = 0; t < 10; t++) begin
            do_reset(1'b0);
            stream.delete();
            nb = 8'($urandom_range(1, 6));
            put(8'h00); put(nb);
            for (int i = 0; i < int'(nb); i++) begin
                w = $urandom;
                if ($urandom_range(0, 7) != 0) w[31:28] = 4'h0;
                put4(w);
            end
            put_checksum();
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) put(8'($urandom));
            model();
            run_stream(2);
            check_run($sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
